pad_step_sequencer: RTL and testbench

Step sequencer that sits directly upstream of the 16:1 4-bit pad multiplexer. It drives the mux select lines S0..S3 with a tempo-timed step index and loops over a programmable number of steps. It also registers the selected 4-bit pad value returned from the mux into NOTE, with a one-cycle NOTE_VALID strobe for the sound/LED stage downstream.

---
 rtl/pad_seq_pkg.sv | 23 ++
 rtl/pad_step_sequencer_if.sv | 33 +++
 rtl/step_prescaler.sv | 36 +++
 rtl/pad_step_sequencer.sv | 103 ++++++++++
 tb/tb_pad_step_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pad_seq_pkg.sv
// Shared types and constants for the pad step sequencer.
package pad_seq_pkg;

  localparam int unsigned NUM_STEPS = 16;
  localparam int unsigned STEP_W    = $clog2(NUM_STEPS);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSample = 2'd1,
    StWait   = 2'd2
  } seq_state_e;

  // Loop advance: anything at or above the last index wraps to step 0, so a step
  // left stranded above a freshly lowered LEN recovers on the next advance.
  function automatic logic [STEP_W-1:0] next_step(input logic [STEP_W-1:0] step,
                                                  input logic [STEP_W-1:0] last);
    if (step >= last) begin
      return '0;
    end
    return step + STEP_W'(1);
  endfunction

endpackage

// File: rtl/pad_step_sequencer_if.sv
// Control, mux-facing and note-output signals of the pad step sequencer.
interface pad_step_sequencer_if
  import pad_seq_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) ();

  logic                 PLAY;
  logic                 CLR;
  logic [DIV_WIDTH-1:0] TEMPO;
  logic [STEP_W-1:0]    LEN;
  logic [3:0]           Din;
  logic                 S0;
  logic                 S1;
  logic                 S2;
  logic                 S3;
  logic [3:0]           NOTE;
  logic                 NOTE_VALID;
  logic [STEP_W-1:0]    STEP;

  // Controller / mux side.
  modport master (
    output PLAY, CLR, TEMPO, LEN, Din,
    input  S0, S1, S2, S3, NOTE, NOTE_VALID, STEP
  );

  // Sequencer side.
  modport slave (
    input  PLAY, CLR, TEMPO, LEN, Din,
    output S0, S1, S2, S3, NOTE, NOTE_VALID, STEP
  );

endinterface

// File: rtl/step_prescaler.sv
// Loadable down-counter that times the WAIT phase between step samples.
module step_prescaler #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] load_val_i,
  input  logic                 en_i,
  output logic                 zero_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pad_step_sequencer.sv
// Tempo-timed step sequencer driving the 16:1 pad mux select and capturing
// the returned pad value as NOTE with a one-cycle NOTE_VALID strobe.
module pad_step_sequencer
  import pad_seq_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  pad_step_sequencer_if.slave  seq_bus
);

  seq_state_e           state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [3:0]           note_q, note_d;
  logic                 note_valid_q, note_valid_d;
  logic                 pre_load;
  logic [DIV_WIDTH-1:0] pre_load_val;
  logic                 pre_en;
  logic                 pre_zero;

  step_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk_i      (CLK),
    .rst_ni     (RST_n),
    .load_i     (pre_load),
    .load_val_i (pre_load_val),
    .en_i       (pre_en),
    .zero_o     (pre_zero)
  );

  // Next-state, step advance, note capture and prescaler control.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    note_d       = note_q;
    note_valid_d = 1'b0;
    pre_load     = 1'b0;
    pre_load_val = seq_bus.TEMPO;
    pre_en       = 1'b0;

    if (seq_bus.CLR) begin
      // Clear overrides the FSM; NOTE is deliberately left untouched.
      step_d       = '0;
      pre_load     = 1'b1;
      pre_load_val = '0;
      state_d      = seq_bus.PLAY ? StSample : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (seq_bus.PLAY) begin
            state_d = StSample;
          end
        end
        StSample: begin
          // Select lines changed at least one edge ago, so Din has settled.
          note_d       = seq_bus.Din;
          note_valid_d = 1'b1;
          pre_load     = 1'b1;
          state_d      = StWait;
        end
        StWait: begin
          if (!seq_bus.PLAY) begin
            state_d = StIdle;
          end else if (!pre_zero) begin
            pre_en = 1'b1;
          end else begin
            step_d  = next_step(step_q, seq_bus.LEN);
            state_d = StSample;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State, step and note registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q      <= StIdle;
      step_q       <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
    end
  end

  assign seq_bus.S0         = step_q[0];
  assign seq_bus.S1         = step_q[1];
  assign seq_bus.S2         = step_q[2];
  assign seq_bus.S3         = step_q[3];
  assign seq_bus.STEP       = step_q;
  assign seq_bus.NOTE       = note_q;
  assign seq_bus.NOTE_VALID = note_valid_q;

endmodule

// File: tb/tb_pad_step_sequencer.sv
// Directed bench for pad_step_sequencer with a pad-mux model and a NOTE scoreboard.
module tb_pad_step_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  pad_step_sequencer_if #(.DIV_WIDTH(16)) seq_bus ();

  pad_step_sequencer #(
    .DIV_WIDTH (16)
  ) dut (
    .CLK     (clk),
    .RST_n   (rst_n),
    .seq_bus (seq_bus)
  );

  always #5 clk = ~clk;

  // Pad mux model: Din follows the select lines combinationally.
  logic [3:0] pad_tbl [16];
  assign seq_bus.Din = pad_tbl[{seq_bus.S3, seq_bus.S2, seq_bus.S1, seq_bus.S0}];

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  logic [3:0] exp_q [$];
  int         pulse_cyc [$];
  logic       prev_valid = 1'b0;
  logic [3:0] s_prev = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every NOTE_VALID pulse pops one expected NOTE.
  always @(negedge clk) begin
    if (seq_bus.NOTE_VALID === 1'b1) begin
      pulse_cyc.push_back(cyc);
      tests++;
      assert (prev_valid === 1'b0) else begin
        fails++;
        $error("FAIL back_to_back_valid: observed %b expected 0", prev_valid);
      end
      tests++;
      assert ((exp_q.size() != 0) === 1'b1) else begin
        fails++;
        $error("FAIL unexpected_pulse: observed pulse NOTE=%0h expected none", seq_bus.NOTE);
      end
      if (exp_q.size() != 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        tests++;
        assert (seq_bus.NOTE === e) else begin
          fails++;
          $error("FAIL note_value: observed %0h expected %0h", seq_bus.NOTE, e);
        end
      end
      tests++;
      assert (seq_bus.NOTE === pad_tbl[s_prev]) else begin
        fails++;
        $error("FAIL s_leads_note: observed %0h expected %0h", seq_bus.NOTE, pad_tbl[s_prev]);
      end
    end
    prev_valid = seq_bus.NOTE_VALID;
    s_prev     = {seq_bus.S3, seq_bus.S2, seq_bus.S1, seq_bus.S0};
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulses(input int target, input int limit, input string tag);
    int g = 0;
    while (pulse_cyc.size() < target && g < limit) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk(tag, pulse_cyc.size(), target);
  endtask

  task automatic set_pads(input int mode);
    for (int k = 0; k < 16; k++) begin
      case (mode)
        0:       pad_tbl[k] = 4'(k);
        1:       pad_tbl[k] = 4'(15 - k);
        default: pad_tbl[k] = 4'(k) ^ 4'h5;
      endcase
    end
  endtask

  task automatic stop_and_clear();
    seq_bus.PLAY = 1'b0;
    seq_bus.CLR  = 1'b1;
    tick(1);
    seq_bus.CLR  = 1'b0;
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] step, input logic [3:0] note);
    chk({tag, "_step"}, seq_bus.STEP, step);
    chk({tag, "_s"}, {seq_bus.S3, seq_bus.S2, seq_bus.S1, seq_bus.S0}, step);
    chk({tag, "_note"}, seq_bus.NOTE, note);
  endtask

  initial begin
    int c;
    int p0;
    logic [3:0] last_note;

    // Reset then idle.
    set_pads(0);
    rst_n         = 1'b0;
    seq_bus.PLAY  = 1'b0;
    seq_bus.CLR   = 1'b0;
    seq_bus.TEMPO = 16'd2;
    seq_bus.LEN   = 4'd15;
    tick(2);
    chk_outputs("reset", 4'd0, 4'd0);
    chk("reset_valid", seq_bus.NOTE_VALID, 1'b0);
    rst_n = 1'b1;
    tick(20);
    chk_outputs("idle", 4'd0, 4'd0);
    chk("idle_no_pulse", pulse_cyc.size(), 0);

    // Basic run, TEMPO=2, full 16-step loop plus wrap.
    for (int k = 0; k < 16; k++) exp_q.push_back(pad_tbl[k]);
    exp_q.push_back(pad_tbl[0]);
    p0 = pulse_cyc.size();
    c  = cyc;
    seq_bus.PLAY = 1'b1;
    wait_pulses(p0 + 17, 17 * 4 + 10, "basic_pulses");
    chk("basic_latency", pulse_cyc[p0], c + 2);
    chk("basic_span", pulse_cyc[p0 + 16] - pulse_cyc[p0], 64);
    chk("basic_gap", pulse_cyc[p0 + 16] - pulse_cyc[p0 + 15], 4);
    stop_and_clear();
    chk_outputs("clr_idle", 4'd0, pad_tbl[0]);

    // Short loop LEN=3, TEMPO=0, then LEN lowered to 1 while at step 3.
    set_pads(1);
    seq_bus.LEN   = 4'd3;
    seq_bus.TEMPO = 16'd0;
    for (int k = 0; k < 7; k++) exp_q.push_back(pad_tbl[k % 4]);
    p0 = pulse_cyc.size();
    c  = cyc;
    seq_bus.PLAY = 1'b1;
    wait_pulses(p0 + 7, 7 * 2 + 10, "short_pulses");
    chk("short_latency", pulse_cyc[p0], c + 2);
    chk("short_span", pulse_cyc[p0 + 6] - pulse_cyc[p0], 12);
    chk("short_at_step3", seq_bus.STEP, 4'd3);
    seq_bus.LEN = 4'd1;
    exp_q.push_back(pad_tbl[3]);
    exp_q.push_back(pad_tbl[0]);
    exp_q.push_back(pad_tbl[1]);
    exp_q.push_back(pad_tbl[0]);
    wait_pulses(p0 + 11, 4 * 2 + 10, "lenlow_pulses");
    chk("lenlow_gap", pulse_cyc[p0 + 10] - pulse_cyc[p0 + 9], 2);
    last_note = pad_tbl[0];
    stop_and_clear();
    chk_outputs("clr_hold", 4'd0, last_note);
    tick(3);
    chk("clr_no_pulse", pulse_cyc.size(), p0 + 11);

    // Pause during WAIT at step 5, then resume.
    set_pads(2);
    seq_bus.LEN   = 4'd15;
    seq_bus.TEMPO = 16'd3;
    for (int k = 0; k < 6; k++) exp_q.push_back(pad_tbl[k]);
    p0 = pulse_cyc.size();
    seq_bus.PLAY = 1'b1;
    wait_pulses(p0 + 6, 6 * 5 + 10, "pause_pre_pulses");
    seq_bus.PLAY = 1'b0;
    tick(10);
    chk_outputs("paused", 4'd5, pad_tbl[5]);
    chk("paused_no_pulse", pulse_cyc.size(), p0 + 6);
    exp_q.push_back(pad_tbl[5]);
    exp_q.push_back(pad_tbl[6]);
    c = cyc;
    seq_bus.PLAY = 1'b1;
    wait_pulses(p0 + 8, 2 * 5 + 10, "resume_pulses");
    chk("resume_latency", pulse_cyc[p0 + 6], c + 2);
    chk("resume_gap", pulse_cyc[p0 + 7] - pulse_cyc[p0 + 6], 5);

    // CLR at step 9 while playing.
    for (int k = 7; k < 10; k++) exp_q.push_back(pad_tbl[k]);
    wait_pulses(p0 + 11, 3 * 5 + 10, "clr_pre_pulses");
    chk("clr_at_step9", seq_bus.STEP, 4'd9);
    exp_q.push_back(pad_tbl[0]);
    c = cyc;
    seq_bus.CLR = 1'b1;
    tick(1);
    seq_bus.CLR = 1'b0;
    chk("clr_step0", seq_bus.STEP, 4'd0);
    wait_pulses(p0 + 12, 10, "clr_play_pulse");
    chk("clr_play_latency", pulse_cyc[p0 + 11], c + 2);

    // Synchronous reset mid-WAIT at step 7.
    for (int k = 1; k < 8; k++) exp_q.push_back(pad_tbl[k]);
    wait_pulses(p0 + 19, 7 * 5 + 10, "rst_pre_pulses");
    chk("rst_at_step7", seq_bus.STEP, 4'd7);
    rst_n = 1'b0;
    tick(1);
    chk_outputs("midrst", 4'd0, 4'd0);
    chk("midrst_valid", seq_bus.NOTE_VALID, 1'b0);
    rst_n = 1'b1;
    c = cyc;
    exp_q.push_back(pad_tbl[0]);
    wait_pulses(p0 + 20, 10, "post_rst_pulse");
    chk("post_rst_latency", pulse_cyc[p0 + 19], c + 2);
    seq_bus.PLAY = 1'b0;
    tick(3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
